// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter that feeds single SDRAM transactions to a memory controller.
// One transaction is in flight at a time, and a watchdog turns a hung transaction into an error ack.
module sdram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_rd_enable,
    output logic              mem_wr_enable,
    input  logic              mem_busy,
    input  logic              mem_rd_ready,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              grant,
    output logic              timeout_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic [7:0]        wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_en_q, rd_en_d;
    logic              wr_en_q, wr_en_d;

    logic              win_port;
    logic              win_we;
    logic [7:0]        wdog_inc;
    logic              wdog_hit;
    logic              finish;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        addr_d        = addr_q;
        we_d          = we_q;
        wdata_d       = wdata_q;
        rd_en_d       = rd_en_q;
        wr_en_d       = wr_en_q;
        finish        = 1'b0;

        // A lone requester wins; on a tie the port that did not win last time goes.
        win_port = (p0_req && p1_req) ? ~last_grant_q : p1_req;
        win_we   = win_port ? p1_we : p0_we;
        wdog_inc = (wdog_q == TIMEOUT_C) ? wdog_q : wdog_q + 8'd1;
        wdog_hit = (wdog_inc == TIMEOUT_C);

        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    state_d      = S_ISSUE;
                    grant_d      = win_port;
                    last_grant_d = win_port;
                    addr_d       = win_port ? p1_addr : p0_addr;
                    wdata_d      = win_port ? p1_wdata : p0_wdata;
                    we_d         = win_we;
                    rd_en_d      = ~win_we;
                    wr_en_d      = win_we;
                    wdog_d       = 8'd0;
                end
            end
            S_ISSUE: begin
                wdog_d = wdog_inc;
                // The controller ignores enables during refresh, so keep them up until it goes busy.
                if (mem_busy) begin
                    state_d = S_WAIT;
                    rd_en_d = 1'b0;
                    wr_en_d = 1'b0;
                end else if (wdog_hit) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end
            end
            S_WAIT: begin
                wdog_d = wdog_inc;
                if (!we_q && mem_rd_ready) begin
                    if (grant_q) rdata1_d = mem_rd_data;
                    else         rdata0_d = mem_rd_data;
                    finish = 1'b1;
                end else if (we_q && !mem_busy) begin
                    finish = 1'b1;
                end else if (wdog_hit) begin
                    timeout_err_d = 1'b1;
                    finish        = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // DONE carries the ack and blocks arbitration for a cycle, so a req still high during ack is not re-served.
        if (finish) begin
            state_d = S_DONE;
            rd_en_d = 1'b0;
            wr_en_d = 1'b0;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            last_grant_q  <= 1'b1;
            grant_q       <= 1'b0;
            wdog_q        <= 8'd0;
            timeout_err_q <= 1'b0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            wdata_q       <= '0;
            rd_en_q       <= 1'b0;
            wr_en_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            wdata_q       <= wdata_d;
            rd_en_q       <= rd_en_d;
            wr_en_q       <= wr_en_d;
        end
    end

    assign p0_ack        = ack0_q;
    assign p1_ack        = ack1_q;
    assign p0_rdata      = rdata0_q;
    assign p1_rdata      = rdata1_q;
    assign mem_rd_addr   = addr_q;
    assign mem_wr_addr   = addr_q;
    assign mem_wr_data   = wdata_q;
    assign mem_rd_enable = rd_en_q;
    assign mem_wr_enable = wr_en_q;
    assign grant         = grant_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: the bench plays both requesters and the memory controller.
// A transaction-level model tracks round-robin order, per-port read data and the sticky error.
module tb_sdram_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req, p0_we, p0_ack, p1_req, p1_we, p1_ack;
    logic [AW-1:0] p0_addr, p1_addr, mem_rd_addr, mem_wr_addr;
    logic [DW-1:0] p0_wdata, p0_rdata, p1_wdata, p1_rdata, mem_wr_data, mem_rd_data;
    logic          mem_rd_enable, mem_wr_enable, mem_busy, mem_rd_ready, grant, timeout_err;

    // Requester-side intent; ports are driven straight from these.
    logic          r_req[2];
    logic          r_we[2];
    logic [AW-1:0] r_addr[2];
    logic [DW-1:0] r_wdata[2];

    // Transaction-level reference state.
    bit            m_last;
    logic [DW-1:0] m_rdata[2];
    bit            m_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    assign p0_req = r_req[0];  assign p0_we = r_we[0];  assign p0_addr = r_addr[0];  assign p0_wdata = r_wdata[0];
    assign p1_req = r_req[1];  assign p1_we = r_we[1];  assign p1_addr = r_addr[1];  assign p1_wdata = r_wdata[1];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL sim_budget: cycle %0d exceeds limit 60000", cyc);
            $fatal(1, "simulation budget exhausted");
        end
    end

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_enable(mem_rd_enable), .mem_wr_enable(mem_wr_enable),
        .mem_busy(mem_busy), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
        .grant(grant), .timeout_err(timeout_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check(tag, "grant", grant, 0);
        check(tag, "p0_ack", p0_ack, 0);
        check(tag, "p1_ack", p1_ack, 0);
        check(tag, "p0_rdata", p0_rdata, 0);
        check(tag, "p1_rdata", p1_rdata, 0);
        check(tag, "rd_en", mem_rd_enable, 0);
        check(tag, "wr_en", mem_wr_enable, 0);
        check(tag, "rd_addr", mem_rd_addr, 0);
        check(tag, "wr_addr", mem_wr_addr, 0);
        check(tag, "wr_data", mem_wr_data, 0);
        check(tag, "timeout_err", timeout_err, 0);
    endtask

    task automatic model_reset();
        m_last = 1'b1;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        m_err = 1'b0;
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        r_req[p] = 1'b1;
        r_we[p] = we;
        r_addr[p] = a;
        r_wdata[p] = d;
    endtask

    // Act as the controller for one transaction and check it end to end.
    task automatic serve(input string tag, input int busy_dly, input int post_dly,
                         input logic [DW-1:0] mem_word, input bit to_case, input bit chg_addr);
        int n;
        int c0;
        bit p;
        logic e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        c0 = cyc;
        p = (r_req[0] && r_req[1]) ? !m_last : r_req[1];
        e_we = r_we[p];
        e_addr = r_addr[p];
        e_wdata = r_wdata[p];
        n = 0;
        while (!(mem_rd_enable || mem_wr_enable) && n < 20) begin
            tick();
            n++;
        end
        check(tag, "issue_seen", 32'(n < 20), 1);
        m_last = p;
        check(tag, "grant", grant, p);
        check(tag, "rd_en", mem_rd_enable, !e_we);
        check(tag, "wr_en", mem_wr_enable, e_we);
        check(tag, "rd_addr", mem_rd_addr, e_addr);
        check(tag, "wr_addr", mem_wr_addr, e_addr);
        check(tag, "wr_data", mem_wr_data, e_wdata);
        if (chg_addr) r_addr[p] = ~e_addr;
        if (to_case) begin
            n = 0;
            while (!(p0_ack || p1_ack) && n < TO + 10) begin
                tick();
                n++;
            end
            check(tag, "timeout_cycles", n, TO);
            m_err = 1'b1;
        end else begin
            for (int i = 0; i < busy_dly; i++) begin
                tick();
                check(tag, "hold_en", e_we ? mem_wr_enable : mem_rd_enable, 1);
                check(tag, "hold_addr", mem_rd_addr, e_addr);
                check(tag, "hold_wdata", mem_wr_data, e_wdata);
            end
            mem_busy = 1'b1;
            tick();
            check(tag, "en_drop", mem_rd_enable | mem_wr_enable, 0);
            check(tag, "wait_addr", mem_rd_addr, e_addr);
            for (int i = 0; i < post_dly; i++) tick();
            if (e_we) begin
                mem_busy = 1'b0;
            end else begin
                mem_rd_data = mem_word;
                mem_rd_ready = 1'b1;
                m_rdata[p] = mem_word;
            end
            tick();
            mem_rd_ready = 1'b0;
            mem_busy = 1'b0;
            mem_rd_data = 16'($urandom);
        end
        check(tag, "ack_granted", p ? p1_ack : p0_ack, 1);
        check(tag, "ack_other", p ? p0_ack : p1_ack, 0);
        check(tag, "latency_ge3", 32'((cyc - c0) >= 3), 1);
        check(tag, "p0_rdata", p0_rdata, m_rdata[0]);
        check(tag, "p1_rdata", p1_rdata, m_rdata[1]);
        check(tag, "timeout_err", timeout_err, m_err);
        r_req[p] = 1'b0;
        tick();
        check(tag, "ack_pulse", p0_ack | p1_ack, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        mem_busy = 1'b0;
        mem_rd_ready = 1'b0;
        mem_rd_data = '0;
        for (int p = 0; p < 2; p++) begin
            r_req[p] = 1'b0;
            r_we[p] = 1'b0;
            r_addr[p] = '0;
            r_wdata[p] = '0;
        end
        model_reset();

        // Reset values, during reset and after release.
        tick();
        tick();
        check_reset("reset");
        rst_n = 1'b1;
        tick();
        check_reset("release");

        // Single read from port 0.
        set_req(0, 1'b0, 24'h123456, 16'h0000);
        serve("single_rd", 2, 1, 16'hBEEF, 0, 0);

        // Address input changed right after the latch.
        set_req(0, 1'b0, 24'h0ABCDE, 16'h1111);
        serve("addr_chg", 2, 0, 16'h1234, 0, 1);

        // Both ports requesting continuously.
        for (int k = 0; k < 6; k++) begin
            if (!r_req[0]) set_req(0, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            if (!r_req[1]) set_req(1, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            serve("alternate", 0, 1, 16'($urandom), 0, 0);
            check("alternate", "grant_order", grant, k[0] ? 1'b0 : 1'b1);
        end
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;

        // Refresh stall on a write.
        set_req(0, 1'b1, 24'h000FFF, 16'hA5A5);
        serve("refresh", 20, 2, 16'h0000, 0, 0);

        // Controller never goes busy, then the next request must still work.
        set_req(1, 1'b0, 24'h00F00D, 16'h0000);
        serve("timeout", 0, 0, 16'h0000, 1, 0);
        set_req(0, 1'b0, 24'h000042, 16'h0000);
        serve("after_to", 1, 1, 16'h5A5A, 0, 0);

        // Reset in the middle of a port 1 read.
        set_req(1, 1'b0, 24'h654321, 16'h0000);
        n = 0;
        while (!mem_rd_enable && n < 20) begin
            tick();
            n++;
        end
        check("rst_mid", "issue_seen", 32'(n < 20), 1);
        mem_busy = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        r_req[1] = 1'b0;
        mem_busy = 1'b0;
        tick();
        check_reset("rst_mid");
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_mid", "no_ack", p0_ack | p1_ack, 0);
        end
        set_req(0, 1'b0, 24'h111111, 16'h0000);
        set_req(1, 1'b0, 24'h222222, 16'h0000);
        serve("post_rst0", 0, 0, 16'hC0DE, 0, 0);
        serve("post_rst1", 1, 2, 16'hF00D, 0, 0);

        // Random traffic from both ports.
        for (int k = 0; k < 40; k++) begin
            for (int p = 0; p < 2; p++)
                if (!r_req[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            if (!r_req[0] && !r_req[1])
                set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 24'($urandom), 16'($urandom));
            serve("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
